// File: rtl/ucpu_bus_tracer_pkg.sv
// rtl/ucpu_bus_tracer_pkg.sv - shared types and codes for the uCPU bus tracer
//
// Purpose: capture FSM state codes, trigger mode codes and the trace entry
// width helper, shared by the tracer top and its trace memory.
// Ports: none (package).

package ucpu_bus_tracer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_POST  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] TRIG_ROM_ADDR    = 2'd0;
   localparam logic [1:0] TRIG_RAM_WR      = 2'd1;
   localparam logic [1:0] TRIG_RAM_WR_DATA = 2'd2;
   localparam logic [1:0] TRIG_IMMEDIATE   = 2'd3;

   // Entry layout, MSB first: {wr_en, ram_data, ram_addr, rom_data, rom_addr}
   function automatic int entry_width(input int aw, input int rom_dw, input int ram_dw);
      return 1 + ram_dw + aw + rom_dw + aw;
   endfunction

endpackage

// File: rtl/ucpu_bus_tracer_mem.sv
// rtl/ucpu_bus_tracer_mem.sv - DEPTH x EW simple dual-port trace memory
//
// Purpose: one write port, one registered synchronous read port. The array
// itself is not reset; only the read data register is.
// Ports:
//   clk, rst          clock, asynchronous active-high reset (read register only)
//   wr, waddr, wdata  write port
//   rd, raddr         read enable and address; rdata updates on the next edge
//   rdata             registered read data, holds while rd is low

module ucpu_bus_tracer_mem #(
   parameter int DEPTH = 64,
   parameter int PW    = 6,
   parameter int EW    = 37
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr,
   input  logic [PW-1:0] waddr,
   input  logic [EW-1:0] wdata,
   input  logic          rd,
   input  logic [PW-1:0] raddr,
   output logic [EW-1:0] rdata
);

   logic [EW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)     rdata <= '0;
      else if (rd) rdata <= mem[raddr];
   end

endmodule

// File: rtl/ucpu_bus_tracer.sv
// rtl/ucpu_bus_tracer.sv - triggered circular trace buffer for the uCPU buses
//
// Purpose: passively snoops the ROM/RAM buses, records one entry per cycle
// while ARMED/POST, stops post_count entries after the trigger entry, and
// offers the frozen trace for readout with index 0 = oldest retained entry.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   rom_addr, rom_data                snooped ROM bus
//   ram_addr, ram_data, wr_en         snooped RAM bus
//   arm                               clear buffer and start capture
//   trig_mode, trig_addr, trig_data   trigger selection and compare values
//   post_count                        entries kept after the trigger entry
//   state, count, trig_pos            status
//   rd_req, rd_addr                   readout request (honoured in DONE)
//   rd_valid, rd_entry                readout result, one cycle later

module ucpu_bus_tracer
   import ucpu_bus_tracer_pkg::*;
#(
   parameter  int AW     = 8,
   parameter  int ROM_DW = 12,
   parameter  int RAM_DW = 8,
   parameter  int DEPTH  = 64,
   localparam int PW     = $clog2(DEPTH),
   localparam int EW     = entry_width(AW, ROM_DW, RAM_DW)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [AW-1:0]     rom_addr,
   input  logic [ROM_DW-1:0] rom_data,
   input  logic [AW-1:0]     ram_addr,
   input  logic [RAM_DW-1:0] ram_data,
   input  logic              wr_en,
   input  logic              arm,
   input  logic [1:0]        trig_mode,
   input  logic [AW-1:0]     trig_addr,
   input  logic [RAM_DW-1:0] trig_data,
   input  logic [PW-1:0]     post_count,
   output logic [1:0]        state,
   output logic [PW:0]       count,
   output logic [PW-1:0]     trig_pos,
   input  logic              rd_req,
   input  logic [PW-1:0]     rd_addr,
   output logic              rd_valid,
   output logic [EW-1:0]     rd_entry
);

   localparam logic [PW:0]   COUNT_FULL = (PW + 1)'(DEPTH);
   localparam logic [PW:0]   COUNT_ONE  = (PW + 1)'(1);
   localparam logic [PW-1:0] PTR_ONE    = PW'(1);

   state_t        state_q, state_d;
   logic [PW-1:0] wptr_q, pc_q, trig_idx_q, oldest, rd_index;
   logic [PW:0]   count_q;
   logic          trig_hit, capture, rd_fire;
   logic [EW-1:0] entry;

   assign entry = {wr_en, ram_data, ram_addr, rom_data, rom_addr};

   always_comb begin
      trig_hit = 1'b0;
      case (trig_mode)
         TRIG_ROM_ADDR:    trig_hit = (rom_addr == trig_addr);
         TRIG_RAM_WR:      trig_hit = wr_en && (ram_addr == trig_addr);
         TRIG_RAM_WR_DATA: trig_hit = wr_en && (ram_addr == trig_addr) && (ram_data == trig_data);
         TRIG_IMMEDIATE:   trig_hit = 1'b1;
         default:          trig_hit = 1'b0;
      endcase
   end

   // arm takes priority: it restarts the trace and suppresses that cycle's write
   assign capture = !arm && (state_q == ST_ARMED || state_q == ST_POST);

   always_comb begin
      state_d = state_q;
      if (arm) begin
         state_d = ST_ARMED;
      end else begin
         case (state_q)
            ST_ARMED: if (trig_hit) state_d = (post_count != '0) ? ST_POST : ST_DONE;
            ST_POST:  if (pc_q == PTR_ONE) state_d = ST_DONE;
            default:  state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         wptr_q     <= '0;
         count_q    <= '0;
         pc_q       <= '0;
         trig_idx_q <= '0;
         rd_valid   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rd_valid <= rd_fire;
         if (arm) begin
            wptr_q     <= '0;
            count_q    <= '0;
            trig_idx_q <= '0;
         end else if (capture) begin
            wptr_q <= wptr_q + PTR_ONE;
            if (count_q != COUNT_FULL) count_q <= count_q + COUNT_ONE;
            if (state_q == ST_ARMED && trig_hit) begin
               trig_idx_q <= wptr_q;
               pc_q       <= post_count;
            end else if (state_q == ST_POST) begin
               pc_q <= pc_q - PTR_ONE;
            end
         end
      end
   end

   // Once the buffer has wrapped, the slot about to be overwritten is the oldest
   assign oldest   = (count_q == COUNT_FULL) ? wptr_q : '0;
   assign trig_pos = trig_idx_q - oldest;
   assign rd_fire  = rd_req && (state_q == ST_DONE);
   assign rd_index = oldest + rd_addr;
   assign state    = state_q;
   assign count    = count_q;

   ucpu_bus_tracer_mem #(
      .DEPTH (DEPTH),
      .PW    (PW),
      .EW    (EW)
   ) u_mem (
      .clk   (clk),
      .rst   (rst),
      .wr    (capture),
      .waddr (wptr_q),
      .wdata (entry),
      .rd    (rd_fire),
      .raddr (rd_index),
      .rdata (rd_entry)
   );

endmodule
